// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// FSM states and the default operand width.
package mdu_pkg;

   localparam int MDU_WIDTH = 32;

   typedef enum logic [2:0] {
      MD_NOP   = 3'b000,
      MD_MULT  = 3'b001,
      MD_MULTU = 3'b010,
      MD_DIV   = 3'b011,
      MD_DIVU  = 3'b100,
      MD_MTHI  = 3'b101,
      MD_MTLO  = 3'b110
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } mdu_state_e;

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider datapath on unsigned magnitudes, one quotient bit per step.
// The outputs show the quotient/remainder as they will be after the current step.
module mdu_div_core
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient_next,
   output logic [WIDTH-1:0] remainder_next
);

   logic [WIDTH-1:0] quo_reg;
   logic [WIDTH-1:0] rem_reg;
   logic [WIDTH-1:0] dsr_reg;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   trial;

   // The dividend is shifted out of the top of the quotient register while
   // quotient bits are shifted in at the bottom.
   always_comb begin
      rem_shift = {rem_reg, quo_reg[WIDTH-1]};
      trial     = rem_shift - {1'b0, dsr_reg};
      if (rem_shift >= {1'b0, dsr_reg}) begin
         remainder_next = trial[WIDTH-1:0];
         quotient_next  = {quo_reg[WIDTH-2:0], 1'b1};
      end else begin
         remainder_next = rem_shift[WIDTH-1:0];
         quotient_next  = {quo_reg[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         quo_reg <= '0;
         rem_reg <= '0;
         dsr_reg <= '0;
      end else if (load) begin
         quo_reg <= dividend;
         rem_reg <= '0;
         dsr_reg <= divisor;
      end else if (step) begin
         quo_reg <= quotient_next;
         rem_reg <= remainder_next;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU execution unit with architectural HI/LO,
// start/busy/done handshake and flush.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;

   mdu_state_e         state_reg;
   logic [CW-1:0]      count_reg;
   logic               is_div_reg;
   logic               neg_q_reg;
   logic               neg_r_reg;
   logic               div_zero_reg;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   mcand_reg;
   logic [2*WIDTH-1:0] prod_reg;
   logic [WIDTH-1:0]   hi_reg;
   logic [WIDTH-1:0]   lo_reg;
   logic               busy_reg;
   logic               done_reg;

   logic               accept;
   logic               is_muldiv;
   logic               op_div;
   logic               is_signed;
   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               last_iter;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_next;
   logic [2*WIDTH-1:0] prod_signed;
   logic [WIDTH-1:0]   quo_next;
   logic [WIDTH-1:0]   rem_next;
   logic [WIDTH-1:0]   quo_signed;
   logic [WIDTH-1:0]   rem_signed;

   // Starts are only taken outside RUN, and a simultaneous flush suppresses them.
   assign accept    = start && !flush && (state_reg != ST_RUN);
   assign is_muldiv = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   assign op_div    = (op == MD_DIV) || (op == MD_DIVU);
   assign is_signed = (op == MD_MULT) || (op == MD_DIV);
   assign sign_a    = is_signed && a[WIDTH-1];
   assign sign_b    = is_signed && b[WIDTH-1];
   assign a_mag     = sign_a ? -a : a;
   assign b_mag     = sign_b ? -b : b;
   assign last_iter = (count_reg == CW'(WIDTH - 1));

   // Shift-add: multiplier sits in the low half and is consumed LSB first.
   assign mul_sum     = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + (prod_reg[0] ? {1'b0, mcand_reg} : '0);
   assign prod_next   = {mul_sum, prod_reg[WIDTH-1:1]};
   assign prod_signed = neg_q_reg ? -prod_next : prod_next;
   assign quo_signed  = neg_q_reg ? -quo_next : quo_next;
   assign rem_signed  = neg_r_reg ? -rem_next : rem_next;

   mdu_div_core #(
      .WIDTH(WIDTH)
   ) u_div_core (
      .clk           (clk),
      .reset         (reset),
      .load          (accept && op_div),
      .step          ((state_reg == ST_RUN) && !flush),
      .dividend      (a_mag),
      .divisor       (b_mag),
      .quotient_next (quo_next),
      .remainder_next(rem_next)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         count_reg    <= '0;
         is_div_reg   <= 1'b0;
         neg_q_reg    <= 1'b0;
         neg_r_reg    <= 1'b0;
         div_zero_reg <= 1'b0;
         a_reg        <= '0;
         mcand_reg    <= '0;
         prod_reg     <= '0;
         hi_reg       <= '0;
         lo_reg       <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_RUN: begin
               if (flush) begin
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
               end else begin
                  prod_reg  <= prod_next;
                  count_reg <= count_reg + CW'(1);
                  if (last_iter) begin
                     if (!is_div_reg) begin
                        {hi_reg, lo_reg} <= prod_signed;
                     end else if (div_zero_reg) begin
                        hi_reg <= a_reg;
                        lo_reg <= '1;
                     end else begin
                        hi_reg <= rem_signed;
                        lo_reg <= quo_signed;
                     end
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                     state_reg <= ST_DONE;
                  end
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               if (accept) begin
                  if (is_muldiv) begin
                     a_reg        <= a;
                     mcand_reg    <= a_mag;
                     prod_reg     <= {{WIDTH{1'b0}}, b_mag};
                     neg_q_reg    <= sign_a ^ sign_b;
                     neg_r_reg    <= sign_a;
                     div_zero_reg <= (b == '0);
                     is_div_reg   <= op_div;
                     count_reg    <= '0;
                     busy_reg     <= 1'b1;
                     state_reg    <= ST_RUN;
                  end else if (op == MD_MTHI) begin
                     hi_reg <= a;
                  end else if (op == MD_MTLO) begin
                     lo_reg <= a;
                  end
               end
            end
         endcase
      end
   end

   assign busy = busy_reg;
   assign done = done_reg;
   assign hi   = hi_reg;
   assign lo   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed results.
module tb_mult_div_unit;
   import mdu_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [2:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          flush;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk  (clk),
      .reset(reset),
      .start(start),
      .op   (op),
      .a    (a),
      .b    (b),
      .flush(flush),
      .busy (busy),
      .done (done),
      .hi   (hi),
      .lo   (lo)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Issue at the current negedge (IDLE or DONE cycle), wait for done, check results.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo, input bit junk);
      int cyc;
      start = 1'b1; op = o; a = av; b = bv;
      @(negedge clk);
      start = 1'b0; op = MD_NOP;
      check_eq({tag, " busy"}, 64'(busy), 64'd1);
      cyc = 0;
      while (!done && cyc < 40) begin
         if (junk && cyc < 28) begin
            start = 1'b1; op = MD_MTLO; a = 32'hDEAD_BEEF;
         end else begin
            start = 1'b0; op = MD_NOP;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; op = MD_NOP;
      check_eq({tag, " latency"}, 64'(cyc), 64'd32);
      check_eq({tag, " busy_at_done"}, 64'(busy), 64'd0);
      check_eq({tag, " hi"}, 64'(hi), 64'(exp_hi));
      check_eq({tag, " lo"}, 64'(lo), 64'(exp_lo));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit saw_done;
      bit saw_busy;
      reset = 1'b1; start = 1'b0; op = MD_NOP; a = '0; b = '0; flush = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("reset busy", 64'(busy), 64'd0);
      check_eq("reset done", 64'(done), 64'd0);
      check_eq("reset hi", 64'(hi), 64'd0);
      check_eq("reset lo", 64'(lo), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      @(negedge clk);
      check_eq("multu_max done_single", 64'(done), 64'd0);

      run_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      run_op("div_b2b", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      @(negedge clk);

      run_op("divu_junk", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
      run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
      @(negedge clk);

      run_op("divu_zero", MD_DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b0);
      @(negedge clk);
      check_eq("divu_zero done_single", 64'(done), 64'd0);

      // MTHI / MTLO: single cycle, busy never rises
      start = 1'b1; op = MD_MTHI; a = 32'hAAAA_0000;
      @(negedge clk);
      check_eq("mthi hi", 64'(hi), 64'hAAAA_0000);
      check_eq("mthi busy", 64'(busy), 64'd0);
      op = MD_MTLO; a = 32'h5555;
      @(negedge clk);
      start = 1'b0; op = MD_NOP;
      check_eq("mtlo lo", 64'(lo), 64'h5555);
      check_eq("mtlo busy", 64'(busy), 64'd0);
      check_eq("mtlo done", 64'(done), 64'd0);

      // flush and start together: nothing starts, no write
      flush = 1'b1; start = 1'b1; op = MD_MTHI; a = 32'h1234_5678;
      @(negedge clk);
      flush = 1'b0; start = 1'b0; op = MD_NOP;
      check_eq("flush_start hi", 64'(hi), 64'hAAAA_0000);
      check_eq("flush_start busy", 64'(busy), 64'd0);

      // MULTU 5*6 flushed at cycle 10
      start = 1'b1; op = MD_MULTU; a = 32'd5; b = 32'd6;
      @(negedge clk);
      start = 1'b0; op = MD_NOP;
      check_eq("flush busy", 64'(busy), 64'd1);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_eq("flush busy_after", 64'(busy), 64'd0);
      saw_done = 1'b0;
      saw_busy = 1'b0;
      repeat (40) begin
         saw_done |= done;
         saw_busy |= busy;
         @(negedge clk);
      end
      check_eq("flush no_done", 64'(saw_done), 64'd0);
      check_eq("flush no_busy", 64'(saw_busy), 64'd0);
      check_eq("flush hi_kept", 64'(hi), 64'hAAAA_0000);
      check_eq("flush lo_kept", 64'(lo), 64'h5555);

      // DIVU interrupted by reset at cycle 15, MTLO held on start while busy
      start = 1'b1; op = MD_DIVU; a = 32'd1000; b = 32'd3;
      @(negedge clk);
      op = MD_MTLO; a = 32'hFFFF;
      repeat (14) @(negedge clk);
      check_eq("rst busy_before", 64'(busy), 64'd1);
      check_eq("rst lo_ignored", 64'(lo), 64'h5555);
      reset = 1'b1;
      #1;
      check_eq("rst busy", 64'(busy), 64'd0);
      check_eq("rst done", 64'(done), 64'd0);
      check_eq("rst hi", 64'(hi), 64'd0);
      check_eq("rst lo", 64'(lo), 64'd0);
      start = 1'b0; op = MD_NOP;
      @(negedge clk);
      reset = 1'b0;
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         saw_done |= done;
      end
      check_eq("rst no_done", 64'(saw_done), 64'd0);
      check_eq("rst hi_after", 64'(hi), 64'd0);
      check_eq("rst lo_after", 64'(lo), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide execution unit with architectural HI/LO registers, on the execute side of the ALU-op decode path.
- Accepts an op code from the decoder and produces results for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Uses a start/busy/done handshake so the pipeline stalls while a multi-cycle op is in flight.

Parameters:
- WIDTH, 32: operand width. HI and LO are each WIDTH bits wide.

Ports:
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request to execute op this cycle
- op  input  3  000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as NOP)
- a  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
- b  input  WIDTH  rt operand (divisor / multiplier)
- flush  input  1  cancel the in-flight operation
- busy  output  1  high while a multi-cycle op is running
- done  output  1  one-cycle pulse when HI/LO take a multi-cycle result
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous, active-high): busy=0, done=0, hi=0, lo=0, FSM=IDLE, internal counters and accumulators cleared. Reset mid-operation abandons the operation; no done pulse follows.
- FSM has three states: IDLE, RUN, DONE.
- IDLE, start=1 with op MULT/MULTU/DIV/DIVU:
  - Latch a and b; capture signs for signed ops and convert operands to magnitudes.
  - Counter=0; go to RUN; busy=1 from the next cycle.
- IDLE, start=1 with MTHI/MTLO: write a into hi/lo at that edge. busy stays 0, no done pulse, single cycle.
- IDLE, start=1 with NOP or reserved op: no effect.
- RUN:
  - One iteration per cycle for exactly WIDTH cycles: shift-add for multiply, restoring shift-subtract for divide.
  - At the edge completing iteration WIDTH: apply sign correction, load hi/lo, busy=0, done=1, go to DONE.
  - Latency: start edge E0; hi/lo valid and done=1 in the cycle after edge E(WIDTH).
- DONE: done lasts one cycle, then return to IDLE. start in DONE is accepted exactly as in IDLE, so back-to-back ops are possible with no bubble.
- start while busy=1 is ignored, including MTHI/MTLO. The issuer must stall on busy.
- Multiply results:
  - {hi,lo} is the full 2*WIDTH product.
  - Signed: product negated if sign(a) xor sign(b).
- Divide results:
  - lo = quotient, hi = remainder.
  - Signed: quotient negated if sign(a) xor sign(b); remainder takes the sign of a.
  - Signed most-negative / -1: lo=0x80000000, hi=0.
  - Divide by zero (signed or unsigned): hi=a, lo=all ones, normal latency, done pulses.
- flush:
  - flush=1 in RUN: operation abandoned, busy=0 next cycle, FSM=IDLE, no done pulse, hi/lo unchanged.
  - flush and start in the same cycle: flush wins and nothing is started. This includes MTHI/MTLO, which do not write.
  - flush in IDLE/DONE: no effect on hi/lo; done still completes its single pulse.
- hi/lo are only ever changed by reset, a completed multi-cycle op, or an MTHI/MTLO write.

Decomposition:
- Package mdu_pkg holds:
  - the 3-bit op encoding as an enum (MD_NOP, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO);
  - the FSM state enum;
  - the default WIDTH.
- One natural sub-module: mdu_div_core, the restoring-divider datapath (one step per cycle, unsigned magnitudes). It is instantiated by mult_div_unit, which owns the FSM, sign handling, the multiplier and HI/LO.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 32 cycles, then done=1, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=-7, b=2 issued in the DONE cycle -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=7 -> lo=14, hi=2. Then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> hi=0x1234, lo=0xFFFFFFFF after 32 cycles, done pulses once.
- MTHI a=0xAAAA0000, then MTLO a=0x5555 -> hi/lo updated on the next edge, busy never rises. Then MULTU 5*6 with flush at cycle 10 -> busy=0 next cycle, no done, hi=0xAAAA0000, lo=0x5555 retained.
- Assert reset at cycle 15 of a DIVU, with start held high while busy and MTLO attempted -> all outputs 0 immediately. Ignored starts during busy leave results unaffected.
